// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - State and source-select definitions shared by trig_sequencer
package trig_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_WAIT_SEQ = 3'd2,
        ST_HOLDOFF  = 3'd3,
        ST_FIRE     = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] SRC_M3     = 2'b00;
    localparam logic [1:0] SRC_TRACE  = 2'b01;
    localparam logic [1:0] SRC_EITHER = 2'b10;
    localparam logic [1:0] SRC_SEQ    = 2'b11;

    // True when an edge arrives on any source the selection listens to.
    // In sequence mode both sources are of interest, so either one counts.
    function automatic logic src_hit(input logic [1:0] sel, input logic m3_edge,
                                     input logic trace_edge);
        logic hit;
        case (sel)
            SRC_M3:    hit = m3_edge;
            SRC_TRACE: hit = trace_edge;
            default:   hit = m3_edge | trace_edge;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/trig_sequencer_if.sv
// rtl/trig_sequencer_if.sv - Configuration, trigger inputs and status outputs of trig_sequencer
interface trig_sequencer_if #(
    parameter int pCNT_WIDTH  = 16,
    parameter int pFIRE_WIDTH = 8
);
    logic                   I_arm;
    logic [1:0]             I_src_sel;
    logic [pCNT_WIDTH-1:0]  I_holdoff;
    logic [pCNT_WIDTH-1:0]  I_pulse_len;
    logic [pCNT_WIDTH-1:0]  I_window;
    logic [pFIRE_WIDTH-1:0] I_num_trig;
    logic                   I_m3_trig;
    logic                   I_trace_trig;

    logic                   O_trig_out;
    logic                   O_armed;
    logic                   O_capturing;
    logic [2:0]             O_state;
    logic [pFIRE_WIDTH-1:0] O_fire_count;
    logic                   O_missed;

    modport master (
        output I_arm, I_src_sel, I_holdoff, I_pulse_len, I_window, I_num_trig,
               I_m3_trig, I_trace_trig,
        input  O_trig_out, O_armed, O_capturing, O_state, O_fire_count, O_missed
    );

    modport slave (
        input  I_arm, I_src_sel, I_holdoff, I_pulse_len, I_window, I_num_trig,
               I_m3_trig, I_trace_trig,
        output O_trig_out, O_armed, O_capturing, O_state, O_fire_count, O_missed
    );
endinterface

// File: rtl/cdc_sync_edge.sv
// rtl/cdc_sync_edge.sv - Two-flop synchronizer with single-cycle rise/fall pulses
module cdc_sync_edge (
    input  logic clk,
    input  logic resetn,
    input  logic d_async,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    // Two synchronizer stages followed by the edge-history register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d_async;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/trig_sequencer.sv
// rtl/trig_sequencer.sv - Capture-trigger source select, sequencing, holdoff and pulse shaping
module trig_sequencer #(
    parameter int pCNT_WIDTH  = 16,
    parameter int pFIRE_WIDTH = 8
) (
    input  logic              ext_clock,
    input  logic              resetn,
    trig_sequencer_if.slave   bus
);
    import trig_seq_pkg::*;

    logic arm_rise;
    logic arm_fall;

    cdc_sync_edge u_arm_sync (
        .clk     (ext_clock),
        .resetn  (resetn),
        .d_async (bus.I_arm),
        .rise    (arm_rise),
        .fall    (arm_fall)
    );

    logic [1:0]             sh_src;
    logic [pCNT_WIDTH-1:0]  sh_holdoff;
    logic [pCNT_WIDTH-1:0]  sh_pulse;
    logic [pCNT_WIDTH-1:0]  sh_window;
    logic [pFIRE_WIDTH-1:0] sh_num;

    // Host config is sampled once per arm so live edits cannot disturb a run
    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            sh_src     <= '0;
            sh_holdoff <= '0;
            sh_pulse   <= '0;
            sh_window  <= '0;
            sh_num     <= '0;
        end else if (arm_rise) begin
            sh_src     <= bus.I_src_sel;
            sh_holdoff <= bus.I_holdoff;
            sh_pulse   <= bus.I_pulse_len;
            sh_window  <= bus.I_window;
            sh_num     <= bus.I_num_trig;
        end
    end

    logic m3_prev;
    logic trace_prev;
    logic m3_edge;
    logic trace_edge;

    // Previous-edge levels for rising-edge detection of the trigger sources
    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            m3_prev    <= 1'b0;
            trace_prev <= 1'b0;
        end else begin
            m3_prev    <= bus.I_m3_trig;
            trace_prev <= bus.I_trace_trig;
        end
    end

    assign m3_edge    = bus.I_m3_trig & ~m3_prev;
    assign trace_edge = bus.I_trace_trig & ~trace_prev;

    state_t                 state, state_nxt;
    logic [pCNT_WIDTH-1:0]  hold_cnt, hold_cnt_nxt;
    logic [pCNT_WIDTH-1:0]  pulse_cnt, pulse_cnt_nxt;
    logic [pCNT_WIDTH-1:0]  win_cnt, win_cnt_nxt;
    logic [pFIRE_WIDTH-1:0] fire_cnt, fire_cnt_nxt;
    logic                   trig, trig_nxt;
    logic                   missed, missed_nxt;

    logic                   qual_hit;
    logic [pFIRE_WIDTH-1:0] fire_cnt_inc;
    logic [pCNT_WIDTH-1:0]  pulse_load;

    assign qual_hit     = src_hit(sh_src, m3_edge, trace_edge);
    assign fire_cnt_inc = (&fire_cnt) ? fire_cnt : fire_cnt + pFIRE_WIDTH'(1);
    // pulse_cnt holds the remaining high cycles after the entering one
    assign pulse_load   = (sh_pulse == '0) ? '0 : sh_pulse - pCNT_WIDTH'(1);

    // Next-state and counter updates; arm_fall overrides everything outside IDLE
    always_comb begin
        logic go;
        go            = 1'b0;
        state_nxt     = state;
        hold_cnt_nxt  = hold_cnt;
        pulse_cnt_nxt = pulse_cnt;
        win_cnt_nxt   = win_cnt;
        fire_cnt_nxt  = fire_cnt;
        trig_nxt      = 1'b0;
        missed_nxt    = missed;

        case (state)
            ST_IDLE: begin
                if (arm_rise) begin
                    state_nxt    = ST_ARMED;
                    fire_cnt_nxt = '0;
                    missed_nxt   = 1'b0;
                end
            end
            ST_ARMED: begin
                if (sh_src == SRC_SEQ) begin
                    if (m3_edge && trace_edge) begin
                        go = 1'b1;
                    end else if (m3_edge) begin
                        state_nxt   = ST_WAIT_SEQ;
                        win_cnt_nxt = sh_window;
                    end
                end else if (qual_hit) begin
                    go = 1'b1;
                end
            end
            ST_WAIT_SEQ: begin
                if (trace_edge) begin
                    go = 1'b1;
                end else if (m3_edge) begin
                    win_cnt_nxt = sh_window;
                end else if (sh_window != '0) begin
                    if (win_cnt == pCNT_WIDTH'(1)) begin
                        state_nxt = ST_ARMED;
                    end else begin
                        win_cnt_nxt = win_cnt - pCNT_WIDTH'(1);
                    end
                end
            end
            ST_HOLDOFF: begin
                missed_nxt = missed | qual_hit;
                if (hold_cnt == '0) begin
                    state_nxt     = ST_FIRE;
                    trig_nxt      = 1'b1;
                    pulse_cnt_nxt = pulse_load;
                end else begin
                    hold_cnt_nxt = hold_cnt - pCNT_WIDTH'(1);
                end
            end
            ST_FIRE: begin
                missed_nxt = missed | qual_hit;
                if (pulse_cnt == '0) begin
                    fire_cnt_nxt = fire_cnt_inc;
                    if (sh_num != '0 && fire_cnt_inc == sh_num) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ARMED;
                    end
                end else begin
                    pulse_cnt_nxt = pulse_cnt - pCNT_WIDTH'(1);
                    trig_nxt      = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (go) begin
            if (sh_holdoff == '0) begin
                state_nxt     = ST_FIRE;
                trig_nxt      = 1'b1;
                pulse_cnt_nxt = pulse_load;
            end else begin
                state_nxt    = ST_HOLDOFF;
                hold_cnt_nxt = sh_holdoff - pCNT_WIDTH'(1);
            end
        end

        if (arm_fall && state != ST_IDLE) begin
            state_nxt = ST_IDLE;
            trig_nxt  = 1'b0;
        end
    end

    // State, counters and the registered trigger output
    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
            win_cnt   <= '0;
            fire_cnt  <= '0;
            trig      <= 1'b0;
            missed    <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            win_cnt   <= win_cnt_nxt;
            fire_cnt  <= fire_cnt_nxt;
            trig      <= trig_nxt;
            missed    <= missed_nxt;
        end
    end

    assign bus.O_trig_out   = trig;
    assign bus.O_armed      = (state == ST_ARMED) || (state == ST_WAIT_SEQ) ||
                              (state == ST_HOLDOFF) || (state == ST_FIRE);
    assign bus.O_capturing  = (state == ST_HOLDOFF) || (state == ST_FIRE);
    assign bus.O_state      = state;
    assign bus.O_fire_count = fire_cnt;
    assign bus.O_missed     = missed;
endmodule

// File: tb/tb_trig_sequencer.sv
// tb/tb_trig_sequencer.sv - Directed self-checking bench for trig_sequencer
module tb_trig_sequencer;
    import trig_seq_pkg::*;

    localparam int CW   = 16;
    localparam int FW   = 8;
    localparam int MAXE = 8192;

    logic ext_clock = 1'b0;
    logic resetn    = 1'b0;

    always #5 ext_clock = ~ext_clock;

    trig_sequencer_if #(.pCNT_WIDTH(CW), .pFIRE_WIDTH(FW)) bus();

    trig_sequencer #(.pCNT_WIDTH(CW), .pFIRE_WIDTH(FW)) dut (
        .ext_clock (ext_clock),
        .resetn    (resetn),
        .bus       (bus)
    );

    // Rising edges seen so far; an event "at edge N" is sampled high on edge N
    int edge_n = 0;
    always @(posedge ext_clock) edge_n <= edge_n + 1;

    // exp_hi[c]: trig_out must be high in the cycle following edge c
    bit exp_hi [MAXE];
    bit check_en = 1'b0;
    int tests = 0;
    int fails = 0;
    int e, e0, e1, e3, k;

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge ext_clock);
        #1;
    endtask

    task automatic cfg(input logic [1:0] src, input int h, input int p, input int w, input int n);
        bus.I_src_sel   = src;
        bus.I_holdoff   = CW'(h);
        bus.I_pulse_len = CW'(p);
        bus.I_window    = CW'(w);
        bus.I_num_trig  = FW'(n);
    endtask

    // One-cycle high level on the chosen sources; returns the edge that samples it
    task automatic fire_evt(input bit m, input bit t, output int ev);
        ev = edge_n + 1;
        bus.I_m3_trig    = m;
        bus.I_trace_trig = t;
        step(1);
        bus.I_m3_trig    = 1'b0;
        bus.I_trace_trig = 1'b0;
    endtask

    // A fire for event ev rises 1+h cycles later and lasts max(p,1) cycles
    task automatic expect_fire(input int ev, input int h, input int p);
        int len;
        len = (p == 0) ? 1 : p;
        for (int c = ev + h; c < ev + h + len; c++)
            if (c < MAXE) exp_hi[c] = 1'b1;
    endtask

    task automatic arm();
        bus.I_arm = 1'b1;
        step(3);
        chk("arm_state", int'(bus.O_state), 1);
        chk("arm_armed", int'(bus.O_armed), 1);
        chk("arm_fire_count", int'(bus.O_fire_count), 0);
        chk("arm_missed", int'(bus.O_missed), 0);
    endtask

    task automatic disarm();
        bus.I_arm = 1'b0;
        step(3);
        chk("disarm_state", int'(bus.O_state), 0);
        chk("disarm_trig", int'(bus.O_trig_out), 0);
    endtask

    initial begin
        bus.I_arm        = 1'b0;
        bus.I_m3_trig    = 1'b0;
        bus.I_trace_trig = 1'b0;
        cfg(SRC_M3, 0, 1, 0, 0);

        fork
            forever begin
                @(negedge ext_clock);
                if (check_en)
                    chk($sformatf("trig_out@%0d", edge_n), int'(bus.O_trig_out),
                        (edge_n < MAXE) ? int'(exp_hi[edge_n]) : 0);
            end
        join_none

        step(3);
        chk("rst_trig", int'(bus.O_trig_out), 0);
        chk("rst_armed", int'(bus.O_armed), 0);
        chk("rst_capturing", int'(bus.O_capturing), 0);
        chk("rst_state", int'(bus.O_state), 0);
        chk("rst_fire_count", int'(bus.O_fire_count), 0);
        chk("rst_missed", int'(bus.O_missed), 0);
        resetn = 1'b1;
        step(2);
        check_en = 1'b1;

        // m3 only, zero holdoff, 5-cycle pulse, one fire per arm
        cfg(SRC_M3, 0, 5, 0, 1);
        arm();
        step(5);
        fire_evt(1'b1, 1'b0, e);
        expect_fire(e, 0, 5);
        chk("s1_first_high", int'(bus.O_trig_out), 1);
        step(4);
        chk("s1_last_high", int'(bus.O_trig_out), 1);
        step(1);
        chk("s1_after_pulse", int'(bus.O_trig_out), 0);
        step(2);
        chk("s1_fire_count", int'(bus.O_fire_count), 1);
        chk("s1_state_done", int'(bus.O_state), 5);
        chk("s1_armed", int'(bus.O_armed), 0);
        fire_evt(1'b1, 1'b0, e);
        step(3);
        chk("s1_done_holds", int'(bus.O_state), 5);
        disarm();

        // trace only, holdoff 100, m3 ignored, extra trace during holdoff is missed
        cfg(SRC_TRACE, 100, 1, 0, 1);
        arm();
        fire_evt(1'b1, 1'b0, e);
        step(4);
        fire_evt(1'b1, 1'b0, e);
        step(4);
        chk("s2_m3_ignored", int'(bus.O_state), 1);
        fire_evt(1'b0, 1'b1, e0);
        expect_fire(e0, 100, 1);
        step(19);
        fire_evt(1'b1, 1'b0, e);
        step(3);
        chk("s2_m3_not_missed", int'(bus.O_missed), 0);
        chk("s2_capturing", int'(bus.O_capturing), 1);
        chk("s2_state_holdoff", int'(bus.O_state), 3);
        step(6);
        fire_evt(1'b0, 1'b1, e);
        step(3);
        chk("s2_missed", int'(bus.O_missed), 1);
        step(66);
        chk("s2_before_fire", int'(bus.O_trig_out), 0);
        step(1);
        chk("s2_fire_at_1_plus_h", int'(bus.O_trig_out), 1);
        step(1);
        chk("s2_single_cycle", int'(bus.O_trig_out), 0);
        chk("s2_state_done", int'(bus.O_state), 5);
        chk("s2_fire_count", int'(bus.O_fire_count), 1);
        chk("s2_missed_sticky", int'(bus.O_missed), 1);
        disarm();

        // sequence mode, window 8
        cfg(SRC_SEQ, 0, 3, 8, 0);
        arm();
        fire_evt(1'b0, 1'b1, e);
        step(3);
        chk("s3_trace_alone", int'(bus.O_state), 1);
        fire_evt(1'b1, 1'b0, e0);
        chk("s3_wait_seq", int'(bus.O_state), 2);
        step(9);
        chk("s3_window_expired", int'(bus.O_state), 1);
        step(2);
        fire_evt(1'b0, 1'b1, e);
        step(5);
        chk("s3_late_trace", int'(bus.O_state), 1);
        fire_evt(1'b1, 1'b0, e1);
        step(4);
        fire_evt(1'b0, 1'b1, e);
        expect_fire(e, 0, 3);
        chk("s3_seq_fire", int'(bus.O_trig_out), 1);
        step(6);
        fire_evt(1'b1, 1'b1, e);
        expect_fire(e, 0, 3);
        step(6);
        fire_evt(1'b1, 1'b0, e3);
        step(5);
        fire_evt(1'b1, 1'b0, e);
        step(5);
        fire_evt(1'b0, 1'b1, e);
        expect_fire(e, 0, 3);
        step(6);
        chk("s3_fire_count", int'(bus.O_fire_count), 3);
        chk("s3_state", int'(bus.O_state), 1);
        disarm();

        // either source, unlimited fires, ten events
        cfg(SRC_EITHER, 3, 2, 0, 0);
        arm();
        for (int i = 0; i < 10; i++) begin
            fire_evt(i % 2 == 0, i % 2 == 1, e);
            expect_fire(e, 3, 2);
            step(19);
        end
        chk("s4_fire_count", int'(bus.O_fire_count), 10);
        chk("s4_state", int'(bus.O_state), 1);
        chk("s4_missed", int'(bus.O_missed), 0);
        disarm();

        // pulse_len 0 acts as 1; fire count saturates
        cfg(SRC_M3, 0, 0, 0, 0);
        arm();
        for (int i = 0; i < 260; i++) begin
            fire_evt(1'b1, 1'b0, e);
            expect_fire(e, 0, 0);
            step(2);
        end
        chk("s5_saturated", int'(bus.O_fire_count), 255);
        chk("s5_state", int'(bus.O_state), 1);
        disarm();

        // disarm truncates a long pulse; fire count untouched
        cfg(SRC_M3, 0, 1000, 0, 0);
        arm();
        fire_evt(1'b1, 1'b0, e);
        expect_fire(e, 0, 1000);
        step(49);
        bus.I_arm = 1'b0;
        k = edge_n;
        for (int c = k + 3; c < e + 1000; c++)
            if (c < MAXE) exp_hi[c] = 1'b0;
        step(2);
        chk("s6_still_high", int'(bus.O_trig_out), 1);
        step(1);
        chk("s6_truncated", int'(bus.O_trig_out), 0);
        chk("s6_state_idle", int'(bus.O_state), 0);
        chk("s6_fire_count", int'(bus.O_fire_count), 0);
        step(3);

        // holdoff edited while armed is ignored; async reset mid-pulse
        cfg(SRC_M3, 4, 3, 0, 0);
        arm();
        bus.I_holdoff = CW'(50);
        step(2);
        fire_evt(1'b1, 1'b0, e);
        expect_fire(e, 4, 3);
        step(5);
        chk("s7_old_holdoff", int'(bus.O_trig_out), 1);
        chk("s7_capturing", int'(bus.O_capturing), 1);
        check_en = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("s7_rst_trig", int'(bus.O_trig_out), 0);
        chk("s7_rst_armed", int'(bus.O_armed), 0);
        chk("s7_rst_capturing", int'(bus.O_capturing), 0);
        chk("s7_rst_state", int'(bus.O_state), 0);
        chk("s7_rst_fire_count", int'(bus.O_fire_count), 0);
        chk("s7_rst_missed", int'(bus.O_missed), 0);
        bus.I_arm = 1'b0;
        step(2);
        resetn = 1'b1;
        step(3);
        chk("s7_post_rst_idle", int'(bus.O_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
